prime_check: RTL and testbench
==============================

# prime_check

Sequential primality tester that consumes candidate values, such as those produced by the prime generator, and classifies them. On a rising edge of `go` it latches `n`, performs trial division through a dedicated modulo sub-unit, and reports whether `n` is prime together with its smallest nontrivial factor. The interface is level/handshake compatible with the generator: `go` is edge-triggered and results are valid while `ready` is high.

## Interface
- `WIDTH_LOG`, default 4: operand width is `WIDTH = 1 << WIDTH_LOG` bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `go`  in  1  start request; a 0→1 transition between consecutive samples starts a test
- `n`  in  WIDTH  candidate; sampled only in the cycle the `go` edge is detected
- `ready`  out  1  high when idle; result outputs are valid
- `error`  out  1  high together with `ready` when the test aborted on a sub-unit error
- `is_prime`  out  1  1 if the last tested `n` is prime
- `factor`  out  WIDTH  smallest divisor ≥2 of `n` (equals `n` when prime); 0 when `n` < 2

## Operation
- States: READY, CHECK, WAIT_MOD, ERROR. Held registers:
  - `cand` (WIDTH bits)
  - `div` (WIDTH bits)
  - `div_sq` (WIDTH+2 bits, so it never wraps)
  - `go_prev`
- Edge detect: `go && !go_prev` in any state, including mid-test, causes:
  - `cand` ← `n`, `div` ← 2, `div_sq` ← 4, state ← CHECK.
  - Any in-flight modulo result is discarded; the new start restarts `mod_unit`.
- CHECK:
  - `cand` < 2 → READY, `is_prime` = 0, `factor` = 0.
  - Else if `div_sq` > `cand` → READY, `is_prime` = 1, `factor` = `cand` (covers 2 and 3).
  - Else pulse `mod_start` with a = `cand`, b = `div`, then go to WAIT_MOD.
- WAIT_MOD:
  - `mod_error` → ERROR.
  - `mod_done` with remainder 0 → READY, `is_prime` = 0, `factor` = `div`.
  - `mod_done` with remainder ≠0 → advance the divisor (see Configuration), update `div_sq` incrementally (`div_sq` + 2·step·`div` + step²), then go to CHECK.
  - No `mod_done` → stay in WAIT_MOD.
- READY/ERROR: hold all results until the next `go` edge.
- Output registers:
  - `ready` = state ∈ {READY, ERROR}.
  - `error` = state == ERROR.
  - `is_prime` and `factor` are written only on the transition into READY; an ERROR transition leaves them unchanged.
- Reset (async, `rst` = 0): state READY, `ready` = 1, `error` = 0, `is_prime` = 0, `factor` = 0, `go_prev` = 0. The `mod_unit` is reset too. Reset mid-test aborts with no result.
- Simultaneous `go` edge and `mod_done`: the `go` edge wins.
- A `go` held high does not retrigger.

## Timing
- A `go` edge sampled at cycle t gives state CHECK and `ready` = 0 at t+1.
- Trivial outcome (`n` < 4, or first CHECK resolves): `ready` = 1 at t+2.
- `mod_unit` raises `mod_done` for one cycle exactly WIDTH cycles after the cycle in which it samples `mod_start`.
- Each trial costs WIDTH+1 cycles, measured CHECK to CHECK.
- A composite result reaches READY the cycle after the `mod_done` that revealed it.
- Results are registered; there is no combinational path from `n` or `go` to any output.

## Configuration
- `PRIME_CHECK_WHEEL_EN`:
  - Defined: divisor sequence is 2, 3, 5, 7, 11, 13, 17, …. After 5 the step alternates +2/+4, skipping multiples of 3.
  - Undefined: sequence is 2, 3, 5, 7, 9, …, step +2 after 3.
- Both builds produce identical `is_prime`/`factor`. Only latency differs.

## Structure
- Shared package `prime_pkg`:
  - state encodings (3-bit localparams)
  - `WIDTH` derivation from `WIDTH_LOG`
  - the divisor-step function reused by the generator
- One sub-module, `mod_unit`:
  - restoring shift-subtract remainder, one quotient bit per cycle
  - ports `clk`, `rst` (async active-low), `start`, `a`, `b`, `done`, `error` (b == 0), `rem`
  - `start` while busy restarts the computation

## Test plan
- Reset then idle → `ready` = 1, `error` = 0, `is_prime` = 0, `factor` = 0; no activity without a `go` edge.
- `n` = 7, WIDTH_LOG = 4, `go` edge at t → one trial (div 2), then CHECK with `div_sq` = 9 > 7. Result: `ready` high at t+19, `is_prime` = 1, `factor` = 7.
- `n` = 9 → trials 2 and 3 → `is_prime` = 0, `factor` = 3, `ready` at t+35.
- `n` ∈ {0, 1, 2, 3} → `ready` at t+2 with (0,0), (0,0), (1,2), (1,3) as (`is_prime`, `factor`).
- `n` = 65521 (largest 16-bit prime) → `is_prime` = 1 with no `div_sq` wrap. `n` = 65535 → `factor` = 3. Latency differs between wheel on and off; results are identical.
- Second `go` edge with `n` = 15 during a WAIT_MOD for `n` = 65521 → old test discarded, `factor` = 3. Asserting `rst` = 0 mid-test returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/prime_pkg.sv
// prime_pkg: definitions shared by the prime checker and the prime generator.
//   - width_of()  : operand width from WIDTH_LOG (WIDTH = 1 << WIDTH_LOG)
//   - ST_*        : 3-bit state encodings, plus the state_t enum built on them
//   - div_step()  : trial-divisor increment (plain odd sequence or 6k+-1 wheel)
package prime_pkg;

    localparam int DEF_WIDTH_LOG = 4;

    function automatic int width_of(input int width_log);
        return 1 << width_log;
    endfunction

    localparam logic [2:0] ST_READY    = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_WAIT_MOD = 3'd2;
    localparam logic [2:0] ST_ERROR    = 3'd3;

    typedef enum logic [2:0] {
        S_READY    = ST_READY,
        S_CHECK    = ST_CHECK,
        S_WAIT_MOD = ST_WAIT_MOD,
        S_ERROR    = ST_ERROR
    } state_t;

    // Step from the current divisor to the next one. The wheel phase toggles
    // once per step taken from 5 upward: 5(+2)7(+4)11(+2)13(+4)17 ...
    function automatic logic [2:0] div_step(input logic is_two, input logic is_three,
                                            input logic phase, input logic wheel);
        if (is_two)          return 3'd1;
        if (is_three)        return 3'd2;
        if (wheel && phase)  return 3'd4;
        return 3'd2;
    endfunction

endpackage

// File: rtl/mod_unit.sv
// mod_unit: restoring shift-subtract remainder, one quotient bit per cycle.
//   clk, rst (async active-low)
//   start : load a/b and begin; a start while busy restarts the computation
//   a, b  : dividend / divisor (WIDTH bits)
//   done  : one-cycle pulse WIDTH cycles after the cycle start is sampled
//   error : one-cycle pulse the cycle after a start with b == 0
//   rem   : a mod b, valid while done is high
module mod_unit
    import prime_pkg::*;
#(
    parameter int WIDTH_LOG = DEF_WIDTH_LOG
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [width_of(WIDTH_LOG)-1:0]  a,
    input  logic [width_of(WIDTH_LOG)-1:0]  b,
    output logic                            done,
    output logic                            error,
    output logic [width_of(WIDTH_LOG)-1:0]  rem
);

    localparam int WIDTH = width_of(WIDTH_LOG);

    logic [WIDTH-1:0]     sh;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH_LOG-1:0] cnt;
    logic                 busy;

    function automatic logic [WIDTH-1:0] rstep(input logic [WIDTH-1:0] r, input logic bi,
                                               input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        t = {r, bi};
        if (t >= {1'b0, d}) t = t - {1'b0, d};
        return t[WIDTH-1:0];
    endfunction

    // The first bit is consumed on the start edge itself so the final bit
    // lands WIDTH-1 edges later and done is visible exactly WIDTH cycles on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh    <= '0;
            b_q   <= '0;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (start) begin
                if (b == '0) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    b_q  <= b;
                    rem  <= rstep('0, a[WIDTH-1], b);
                    sh   <= a << 1;
                    cnt  <= WIDTH_LOG'(WIDTH - 1);
                    busy <= 1'b1;
                end
            end else if (busy) begin
                rem <= rstep(rem, sh[WIDTH-1], b_q);
                sh  <= sh << 1;
                cnt <= cnt - 1'b1;
                if (cnt == WIDTH_LOG'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prime_check.sv
// prime_check: sequential trial-division primality tester.
//   clk, rst (async active-low)
//   go       : 0->1 edge latches n and starts a test (also restarts mid-test)
//   n        : candidate, sampled only on the go edge
//   ready    : idle, results valid
//   error    : test aborted on a modulo sub-unit error (with ready)
//   is_prime : last tested n is prime
//   factor   : smallest divisor >= 2 (n itself when prime, 0 when n < 2)
// Build option: PRIME_CHECK_WHEEL_EN selects the 6k+-1 divisor wheel;
// results are identical either way, only latency changes.
module prime_check
    import prime_pkg::*;
#(
    parameter int WIDTH_LOG = DEF_WIDTH_LOG
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            go,
    input  logic [width_of(WIDTH_LOG)-1:0]  n,
    output logic                            ready,
    output logic                            error,
    output logic                            is_prime,
    output logic [width_of(WIDTH_LOG)-1:0]  factor
);

    localparam int WIDTH = width_of(WIDTH_LOG);
`ifdef PRIME_CHECK_WHEEL_EN
    localparam logic WHEEL = 1'b1;
`else
    localparam logic WHEEL = 1'b0;
`endif

    state_t           state, state_nx;
    logic [WIDTH-1:0] cand, cand_nx;
    logic [WIDTH-1:0] div, div_nx;
    logic [WIDTH+1:0] div_sq, div_sq_nx;   // two spare bits: never wraps past the last trial
    logic             phase, phase_nx;
    logic             go_prev;
    logic             is_prime_nx;
    logic [WIDTH-1:0] factor_nx;

    logic             go_edge;
    logic             mod_start, mod_done, mod_error;
    logic [WIDTH-1:0] mod_rem;
    logic [2:0]       step;
    logic [WIDTH+1:0] step_w;

    assign go_edge = go & ~go_prev;
    assign step    = div_step(div == WIDTH'(2), div == WIDTH'(3), phase, WHEEL);
    assign step_w  = (WIDTH+2)'(step);

    mod_unit #(.WIDTH_LOG(WIDTH_LOG)) u_mod (
        .clk   (clk),
        .rst   (rst),
        .start (mod_start),
        .a     (cand),
        .b     (div),
        .done  (mod_done),
        .error (mod_error),
        .rem   (mod_rem)
    );

    always_comb begin
        state_nx    = state;
        cand_nx     = cand;
        div_nx      = div;
        div_sq_nx   = div_sq;
        phase_nx    = phase;
        is_prime_nx = is_prime;
        factor_nx   = factor;
        mod_start   = 1'b0;
        // A new go edge wins over anything in flight; the stale mod_unit
        // result is ignored and the next CHECK restarts the unit.
        if (go_edge) begin
            cand_nx   = n;
            div_nx    = WIDTH'(2);
            div_sq_nx = (WIDTH+2)'(4);
            phase_nx  = 1'b0;
            state_nx  = S_CHECK;
        end else begin
            case (state)
                S_CHECK: begin
                    if (cand < WIDTH'(2)) begin
                        state_nx    = S_READY;
                        is_prime_nx = 1'b0;
                        factor_nx   = '0;
                    end else if (div_sq > {2'b00, cand}) begin
                        state_nx    = S_READY;
                        is_prime_nx = 1'b1;
                        factor_nx   = cand;
                    end else begin
                        mod_start = 1'b1;
                        state_nx  = S_WAIT_MOD;
                    end
                end
                S_WAIT_MOD: begin
                    if (mod_error) begin
                        state_nx = S_ERROR;
                    end else if (mod_done) begin
                        if (mod_rem == '0) begin
                            state_nx    = S_READY;
                            is_prime_nx = 1'b0;
                            factor_nx   = div;
                        end else begin
                            // (d+s)^2 = d^2 + 2sd + s^2
                            div_nx    = div + WIDTH'(step);
                            div_sq_nx = div_sq + ((step_w * {2'b00, div}) << 1) + step_w * step_w;
                            if (div >= WIDTH'(5)) phase_nx = ~phase;
                            state_nx  = S_CHECK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_READY;
            cand     <= '0;
            div      <= '0;
            div_sq   <= '0;
            phase    <= 1'b0;
            go_prev  <= 1'b0;
            ready    <= 1'b1;
            error    <= 1'b0;
            is_prime <= 1'b0;
            factor   <= '0;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            div      <= div_nx;
            div_sq   <= div_sq_nx;
            phase    <= phase_nx;
            go_prev  <= go;
            ready    <= (state_nx == S_READY) || (state_nx == S_ERROR);
            error    <= (state_nx == S_ERROR);
            is_prime <= is_prime_nx;
            factor   <= factor_nx;
        end
    end

endmodule

// File: tb/tb_prime_check.sv
// Directed bench for prime_check (WIDTH_LOG = 4). Latencies are counted from
// the cycle in which the go edge is sampled; ready is expected at t+lat.
module tb_prime_check;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go  = 1'b0;
    logic [15:0] n   = '0;
    logic        ready, error, is_prime;
    logic [15:0] factor;

    int vec_cnt = 0;
    int err_cnt = 0;

    prime_check #(.WIDTH_LOG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .n        (n),
        .ready    (ready),
        .error    (error),
        .is_prime (is_prime),
        .factor   (factor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a test (go edge sampled on the next edge) and waits for ready.
    task automatic run(input string tag, input logic [15:0] val, input int exp_lat,
                       input logic exp_p, input logic [15:0] exp_f);
        int lat;
        n  = val;
        go = 1'b1;
        tick();
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        go  = 1'b0;
        lat = 1;
        while (!ready && lat < 5000) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"},   32'(lat),      32'(exp_lat));
        chk({tag, "_prime"}, 32'(is_prime), 32'(exp_p));
        chk({tag, "_factor"},32'(factor),   32'(exp_f));
        chk({tag, "_err"},   32'(error),    32'd0);
    endtask

    initial begin
        // reset and idle
        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_prime", 32'(is_prime), 32'd0);
        chk("rst_factor", 32'(factor), 32'd0);
        rst = 1'b1;
        n   = 16'd9;
        repeat (5) tick();
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_factor", 32'(factor), 32'd0);

        // trivial and small cases
        run("n0", 16'd0, 2, 1'b0, 16'd0);
        run("n1", 16'd1, 2, 1'b0, 16'd0);
        run("n2", 16'd2, 2, 1'b1, 16'd2);
        run("n3", 16'd3, 2, 1'b1, 16'd3);
        run("n4", 16'd4, 18, 1'b0, 16'd2);
        run("n7", 16'd7, 19, 1'b1, 16'd7);
        run("n9", 16'd9, 35, 1'b0, 16'd3);
        run("n25", 16'd25, 52, 1'b0, 16'd5);
        run("n49", 16'd49, 69, 1'b0, 16'd7);
`ifdef PRIME_CHECK_WHEEL_EN
        run("n121", 16'd121, 86, 1'b0, 16'd11);
        run("n65521", 16'd65521, 1464, 1'b1, 16'd65521);
`else
        run("n121", 16'd121, 103, 1'b0, 16'd11);
        run("n65521", 16'd65521, 2178, 1'b1, 16'd65521);
`endif
        run("n65535", 16'd65535, 35, 1'b0, 16'd3);

        // go held high does not retrigger; results hold
        n  = 16'd10;
        go = 1'b1;
        tick();
        chk("hold_busy", 32'(ready), 32'd0);
        repeat (20) tick();
        chk("hold_ready", 32'(ready), 32'd1);
        chk("hold_factor", 32'(factor), 32'd2);
        n = 16'd9;
        repeat (10) tick();
        chk("hold_noretrig", 32'(ready), 32'd1);
        chk("hold_factor2", 32'(factor), 32'd2);
        go = 1'b0;
        tick();

        // restart mid-test: 65521 discarded in favour of 15
        n  = 16'd65521;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (30) tick();
        chk("restart_busy", 32'(ready), 32'd0);
        run("restart15", 16'd15, 35, 1'b0, 16'd3);
        repeat (40) tick();
        chk("restart_stale", 32'(factor), 32'd3);

        // async reset mid-test
        n  = 16'd65521;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_error", 32'(error), 32'd0);
        chk("arst_prime", 32'(is_prime), 32'd0);
        chk("arst_factor", 32'(factor), 32'd0);
        tick();
        rst = 1'b1;
        repeat (30) tick();
        chk("arst_idle", 32'(ready), 32'd1);
        chk("arst_idle_f", 32'(factor), 32'd0);
        run("after_rst", 16'd21, 35, 1'b0, 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
